// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: radix-2 shift-add multiply and
// restoring shift-subtract divide, one bit per cycle, valid/ready on both sides.
module muldiv_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] operand_a_i,
  input  logic [XLEN-1:0] operand_b_i,
  input  logic            kill_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);

  localparam logic [2:0] OpMul    = 3'd0;
  localparam logic [2:0] OpMulh   = 3'd1;
  localparam logic [2:0] OpMulhsu = 3'd2;
  localparam logic [2:0] OpDiv    = 3'd4;
  localparam logic [2:0] OpRem    = 3'd6;

  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [2*XLEN-1:0]   prod_q, prod_d;   // mul: {acc, multiplier}; div: {rem, quotient}
  logic [XLEN-1:0]     b_q, b_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                neg_res_q, neg_res_d;
  logic                neg_rem_q, neg_rem_d;
  logic [XLEN-1:0]     result_q, result_d;

  // Operand sign handling at accept.
  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;

  assign a_signed = (op_i == OpMulh) || (op_i == OpMulhsu) || (op_i == OpDiv) || (op_i == OpRem);
  assign b_signed = (op_i == OpMulh) || (op_i == OpDiv) || (op_i == OpRem);
  assign a_neg    = a_signed & operand_a_i[XLEN-1];
  assign b_neg    = b_signed & operand_b_i[XLEN-1];
  assign a_mag    = a_neg ? -operand_a_i : operand_a_i;
  assign b_mag    = b_neg ? -operand_b_i : operand_b_i;

  // One iteration of each datapath.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_shift;
  logic              div_ge;
  logic [XLEN-1:0]   div_sub;
  logic [2*XLEN-1:0] div_next;

  assign mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
  assign mul_next  = {mul_sum, prod_q[XLEN-1:1]};
  assign div_shift = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
  assign div_ge    = div_shift >= {1'b0, b_q};
  assign div_sub   = div_shift[XLEN-1:0] - b_q;
  assign div_next  = div_ge ? {div_sub, prod_q[XLEN-2:0], 1'b1}
                            : {div_shift[XLEN-1:0], prod_q[XLEN-2:0], 1'b0};

  // Sign fix-up and result selection applied to the final iteration's output.
  logic [2*XLEN-1:0] step_next, prod_fix;
  logic [XLEN-1:0]   quo_raw, rem_raw, quo_fix, rem_fix, fin_result;

  assign step_next = op_q[2] ? div_next : mul_next;
  assign prod_fix  = neg_res_q ? -step_next : step_next;
  assign quo_raw   = step_next[XLEN-1:0];
  assign rem_raw   = step_next[2*XLEN-1:XLEN];
  assign quo_fix   = neg_res_q ? -quo_raw : quo_raw;
  assign rem_fix   = neg_rem_q ? -rem_raw : rem_raw;

  always_comb begin
    fin_result = rem_fix;
    if (!op_q[2]) begin
      fin_result = (op_q == OpMul) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    end else if (!op_q[1]) begin
      fin_result = quo_fix;
    end
  end

  assign ready_o  = (state_q == StIdle) && !kill_i;
  assign valid_o  = (state_q == StDone);
  assign busy_o   = (state_q != StIdle);
  assign result_o = result_q;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    prod_d    = prod_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    unique case (state_q)
      StIdle: begin
        if (valid_i && ready_o) begin
          op_d      = op_i;
          b_d       = b_mag;
          prod_d    = {{XLEN{1'b0}}, a_mag};
          cnt_d     = CNT_W'(XLEN);
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          if (op_i[2] && (operand_b_i == '0)) begin
            result_d = op_i[1] ? operand_a_i : '1;
            state_d  = StDone;
          end else if (((op_i == OpDiv) || (op_i == OpRem)) &&
                       (operand_a_i == MinNeg) && (operand_b_i == '1)) begin
            result_d = op_i[1] ? '0 : operand_a_i;
            state_d  = StDone;
          end else begin
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        if (kill_i) begin
          state_d = StIdle;
        end else if (cnt_q == CNT_W'(1)) begin
          prod_d   = step_next;
          cnt_d    = '0;
          result_d = fin_result;
          state_d  = StDone;
        end else begin
          prod_d = step_next;
          cnt_d  = cnt_q - CNT_W'(1);
        end
      end
      StDone: begin
        if (kill_i || ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      op_q      <= '0;
      prod_q    <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      prod_q    <= prod_d;
      b_q       <= b_d;
      cnt_q     <= cnt_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at XLEN=32.
module tb_muldiv_unit;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            valid_i = 1'b0;
  logic            ready_o;
  logic [2:0]      op_i = 3'd0;
  logic [XLEN-1:0] operand_a_i = '0;
  logic [XLEN-1:0] operand_b_i = '0;
  logic            kill_i = 1'b0;
  logic            valid_o;
  logic            ready_i = 1'b0;
  logic [XLEN-1:0] result_o;
  logic            busy_o;

  int checks = 0;
  int failures = 0;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .op_i        (op_i),
    .operand_a_i (operand_a_i),
    .operand_b_i (operand_b_i),
    .kill_i      (kill_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .result_o    (result_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  // Present one request at an idle unit and wait for valid_o. lat counts edges with the
  // accept edge as edge 1.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output bit busy_ok);
    valid_i = 1'b1; op_i = op; operand_a_i = a; operand_b_i = b;
    @(posedge clk); #1;
    valid_i = 1'b0;
    lat = 1;
    busy_ok = 1'b1;
    while (!valid_o && lat < 200) begin
      if (!busy_o) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_result();
    ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
    checks++; if (result_o !== 32'h0) begin failures++; $display("FAIL reset_result: got %h expected 0", result_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", ready_o); end
  endtask

  task automatic test_mul();
    logic [2:0]  ops [4] = '{3'd0, 3'd1, 3'd2, 3'd3};
    logic [31:0] as  [4] = '{32'h7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] bs  [4] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] exp [4] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFF, 32'hFFFFFFFE};
    int lat; bit bok;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], as[i], bs[i], lat, bok);
      checks++; if (result_o !== exp[i]) begin failures++; $display("FAIL mul_result[%0d]: got %h expected %h", i, result_o, exp[i]); end
      checks++; if (lat != 33) begin failures++; $display("FAIL mul_latency[%0d]: got %0d expected 33", i, lat); end
      checks++; if (!bok) begin failures++; $display("FAIL mul_busy[%0d]: got busy low expected high", i); end
      release_result();
    end
  endtask

  task automatic test_div();
    logic [2:0]  ops [4] = '{3'd4, 3'd6, 3'd5, 3'd7};
    logic [31:0] as  [4] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'h7, 32'h7};
    logic [31:0] bs  [4] = '{32'h2, 32'h2, 32'h2, 32'h2};
    logic [31:0] exp [4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h3, 32'h1};
    int lat; bit bok;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], as[i], bs[i], lat, bok);
      checks++; if (result_o !== exp[i]) begin failures++; $display("FAIL div_result[%0d]: got %h expected %h", i, result_o, exp[i]); end
      checks++; if (lat != 33) begin failures++; $display("FAIL div_latency[%0d]: got %0d expected 33", i, lat); end
      release_result();
    end
  endtask

  task automatic test_fast_path();
    logic [2:0]  ops [4] = '{3'd5, 3'd6, 3'd4, 3'd6};
    logic [31:0] as  [4] = '{32'h5, 32'h5, 32'h80000000, 32'h80000000};
    logic [31:0] bs  [4] = '{32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] exp [4] = '{32'hFFFFFFFF, 32'h5, 32'h80000000, 32'h0};
    int lat; bit bok;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], as[i], bs[i], lat, bok);
      checks++; if (result_o !== exp[i]) begin failures++; $display("FAIL fast_result[%0d]: got %h expected %h", i, result_o, exp[i]); end
      checks++; if (lat != 1) begin failures++; $display("FAIL fast_latency[%0d]: got %0d expected 1", i, lat); end
      release_result();
    end
  endtask

  task automatic test_backpressure();
    int lat; bit bok; bit stable_ok;
    run_op(3'd5, 32'd100, 32'd7, lat, bok);
    checks++; if (result_o !== 32'd14) begin failures++; $display("FAIL bp_result: got %h expected %h", result_o, 32'd14); end
    valid_i = 1'b1; op_i = 3'd5; operand_a_i = 32'd9; operand_b_i = 32'd3;
    stable_ok = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (!valid_o || result_o !== 32'd14 || ready_o !== 1'b0) stable_ok = 1'b0;
    end
    checks++; if (!stable_ok) begin failures++; $display("FAIL bp_hold: got unstable/ready expected held valid=1 result=e ready=0"); end
    valid_i = 1'b0;
    release_result();
    checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL bp_release_valid: got %b expected 0", valid_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL bp_release_busy: got %b expected 0", busy_o); end
    checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL bp_release_ready: got %b expected 1", ready_o); end
    run_op(3'd5, 32'd9, 32'd3, lat, bok);
    checks++; if (result_o !== 32'd3) begin failures++; $display("FAIL bp_next_result: got %h expected 3", result_o); end
    checks++; if (lat != 33) begin failures++; $display("FAIL bp_next_latency: got %0d expected 33", lat); end
    release_result();
  endtask

  task automatic test_kill();
    int lat; bit bok; bit seen;
    // kill_i in IDLE blocks acceptance.
    kill_i = 1'b1; valid_i = 1'b1; op_i = 3'd0; operand_a_i = 32'd3; operand_b_i = 32'd4;
    #1;
    checks++; if (ready_o !== 1'b0) begin failures++; $display("FAIL kill_idle_ready: got %b expected 0", ready_o); end
    @(posedge clk); #1;
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL kill_idle_accept: got busy %b expected 0", busy_o); end
    kill_i = 1'b0;
    op_i = 3'd5; operand_a_i = 32'd100; operand_b_i = 32'd7;
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (11) begin @(posedge clk); #1; end
    kill_i = 1'b1; valid_i = 1'b1;
    @(posedge clk); #1;
    kill_i = 1'b0; valid_i = 1'b0;
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL kill_busy: got %b expected 0", busy_o); end
    checks++; if (result_o !== 32'd3) begin failures++; $display("FAIL kill_result_held: got %h expected 3", result_o); end
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (valid_o || busy_o) seen = 1'b1;
    end
    checks++; if (seen) begin failures++; $display("FAIL kill_no_valid: got activity expected none"); end
    run_op(3'd7, 32'd100, 32'd7, lat, bok);
    checks++; if (result_o !== 32'd2) begin failures++; $display("FAIL kill_next_result: got %h expected 2", result_o); end
    checks++; if (lat != 33) begin failures++; $display("FAIL kill_next_latency: got %0d expected 33", lat); end
    release_result();
  endtask

  task automatic test_reset_mid_calc();
    int lat; bit bok;
    valid_i = 1'b1; op_i = 3'd0; operand_a_i = 32'h7; operand_b_i = 32'hFFFFFFFD;
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    #3 rst = 1'b1;
    #1;
    checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL rst_mid_valid: got %b expected 0", valid_o); end
    checks++; if (result_o !== 32'h0) begin failures++; $display("FAIL rst_mid_result: got %h expected 0", result_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL rst_mid_busy: got %b expected 0", busy_o); end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL rst_mid_ready: got %b expected 1", ready_o); end
    run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bok);
    checks++; if (result_o !== 32'hFFFFFFFE) begin failures++; $display("FAIL rst_next_result: got %h expected fffffffe", result_o); end
    release_result();
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_fast_path();
    test_backpressure();
    test_kill();
    test_reset_mid_calc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
